// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state type, frame constants, baud helper.
// Optional even-parity support is enabled with UART_PARITY_EN.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;
`endif

    function automatic int unsigned calc_clks_per_bit(int unsigned clk_freq, int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; flops reset (sync, active-low) to RESET_VAL.
module sync_2ff #(
    parameter int unsigned            WIDTH     = 1,
    parameter logic [WIDTH-1:0]       RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with cycle-counted oversampling and a valid/ack holding register.
// Define UART_PARITY_EN to expect an even parity bit between data and stop.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy,
    output logic       parity_error
);

    localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
    localparam int unsigned    BW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_next;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 half_tick, full_tick, stop_sample, parity_bad;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State register plus the datapath that advances with it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state || state == ST_IDLE) ? '0 : cnt + 1'b1;
            if (state == ST_START)
                bit_idx <= '0;
            else if (state == ST_DATA && full_tick) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!rx_s) state_next = ST_START;
            ST_START:  if (half_tick) state_next = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:
                if (full_tick && bit_idx == LAST_BIT)
`ifdef UART_PARITY_EN
                    state_next = ST_PARITY;
            ST_PARITY: if (full_tick) state_next = ST_STOP;
`else
                    state_next = ST_STOP;
`endif
            ST_STOP:   if (full_tick) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        half_tick   = (cnt == CNT_HALF);
        full_tick   = (cnt == CNT_FULL);
        stop_sample = (state == ST_STOP) && full_tick;
    end

`ifdef UART_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (!reset)
            par_bit <= 1'b0;
        else if (state == ST_PARITY && full_tick)
            par_bit <= rx_s;
    end

    // Even parity: the parity bit must equal the XOR of the data bits
    assign parity_bad = (par_bit != ^shift);

    always_ff @(posedge clk) begin
        if (!reset)
            parity_error <= 1'b0;
        else
            parity_error <= stop_sample && parity_bad;
    end
`else
    assign parity_bad   = 1'b0;
    assign parity_error = 1'b0;
`endif

    // Holding register: a completion overrides a same-cycle ack, which suppresses overrun
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= stop_sample && !rx_s;
            if (data_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
            if (stop_sample && rx_s && !parity_bad) begin
                data_out   <= shift;
                data_valid <= 1'b1;
                if (data_valid && !data_ack)
                    overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial 8N1 UART receiver for the board's UART_RXD pin; the receiving end of the UART link whose TXD side the top level already exposes.
- Runs on CLOCK_50 and oversamples by cycle counting, with no derived clock.
- Delivers received bytes to user logic (LEDs, HEX decoders, control FSMs) through a valid/ack holding register, with frame-error and overrun reporting.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- BAUD, 115200, line bit rate in baud.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer, 434 at defaults), clock cycles per bit. Must be ≥ 8.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line; idle is high.
- data_ack  input  1  consumer acknowledge; clears data_valid and overrun.
- data_out  output  8  last received byte, LSB first on the line.
- data_valid  output  1  high from frame completion until data_ack.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; a new byte completed while data_valid was already high.
- busy  output  1  high whenever the FSM is not in IDLE.
- parity_error  output  1  one-cycle pulse on parity mismatch; tied 0 without UART_PARITY_EN.

Behaviour:
- One clock; reset is synchronous and active-low (clk, reset).
- rx passes through a 2-FF synchronizer before use; both FFs reset to 1.
- Reset (including mid-frame):
  - FSM goes to IDLE; bit counter and cycle counter cleared.
  - data_out=0, data_valid=0, overrun=0, frame_error=0, parity_error=0, busy=0.
  - A partially received frame is discarded.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE: when the synchronized rx is 0, go to START and clear the cycle counter.
- START: count to CLKS_PER_BIT/2−1, then sample.
  - Sample 0: go to DATA, bit index = 0.
  - Sample 1: glitch; return to IDLE with no flags raised.
- DATA: count to CLKS_PER_BIT−1, then sample into shift[bit index].
  - After bit 7, go to STOP, or to PARITY when UART_PARITY_EN is defined.
- STOP: count to CLKS_PER_BIT−1, then sample and return to IDLE in the same cycle, so the next start edge is detectable after half a stop bit.
  - Sample 1: the next cycle shows data_out = shift, data_valid = 1.
  - Sample 0: frame_error pulses for 1 cycle; data_out and data_valid are unchanged.
- Latency: data_valid rises CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 3 cycles after the rx pin falls (± 1 cycle from synchronizer alignment).
- Completion while data_valid = 1 and no data_ack that cycle: data_out is overwritten, overrun = 1.
- data_ack in the same cycle as a completion: data_valid stays 1 with the new byte; overrun is not set.
- data_ack with data_valid = 0: no effect.
- Counter widths are $clog2(CLKS_PER_BIT); no wrap-around, because every count is cleared on each state transition.
- rx held low continuously (break): frame_error pulses once per 10-bit frame time. No lock-up.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; it samples at the bit center.
  - Even parity over the 8 data bits is expected.
  - On mismatch, parity_error pulses 1 cycle when the stop bit is sampled, and the byte is discarded (data_valid is not raised).
  - The frame becomes 11 bits; latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state; parity_error is constant 0.

Decomposition:
- Package uart_pkg:
  - state enum type rx_state_t.
  - DATA_BITS = 8.
  - function calc_clks_per_bit(clk_freq, baud).
  - shared with a future uart_transmitter.
- Sub-module sync_2ff: a 2-flop synchronizer with a reset value parameter (default 1). Reused later for KEY/SW inputs.

Test Plan (CLK_FREQ=1_600_000, BAUD=100_000, so CLKS_PER_BIT=16):
- Send 0xA5 in 8N1 → data_out=0xA5 and data_valid=1 at 155±1 cycles after the falling edge; frame_error=0; busy returns to 0. Pulse data_ack → data_valid=0.
- 4-cycle low glitch on idle rx → FSM re-enters IDLE; data_valid, frame_error and busy all end 0 within 12 cycles.
- 0x3C sent with the stop bit forced to 0 → frame_error pulses exactly 1 cycle; data_valid stays 0; data_out keeps its previous value.
- 0x11 then 0x22 back-to-back, no ack → data_out=0x22, data_valid=1, overrun=1. data_ack → both clear.
- reset asserted during bit 3 of 0xFF, then released, then 0x3C sent → all outputs 0 during reset; 0x3C received cleanly, no errors.
- With UART_PARITY_EN: 0x07 with parity bit 1 → accepted. 0x07 with parity bit 0 → parity_error pulse, data_valid stays 0.
